txn_wr_buffer: RTL and testbench

TXN_WR_BUFFER -- requirements
Module: txn_wr_buffer

---
 rtl/txn_wr_buffer.sv | 159 +++++++++++++++
 tb/tb_txn_wr_buffer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/txn_wr_buffer.sv
// txn_wr_buffer: posted-write buffer between a fabric port and a memory port.
// Writes are queued in a DEPTH-entry FIFO and drained in order. A read blocks
// the fabric port until every earlier write has drained and the read completes.
// Optional feature: define TXN_WR_BUFFER_FWD_EN to compile in read-after-write
// forwarding from the youngest matching buffered write.
//
// state   | meaning
// M_IDLE  | no downstream access outstanding; waiting for m_rdy and work
// M_ISSUE | m_req asserted for one cycle with the selected access
// M_WAIT  | access issued; waiting for m_rdy to mark completion
module txn_wr_buffer #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     s_req,
   input  logic                     s_wr,
   input  logic [31:0]              s_addr,
   input  logic [31:0]              s_wdata,
   output logic [31:0]              s_rdata,
   output logic                     s_rdy,
   output logic                     m_req,
   output logic                     m_wr,
   output logic [31:0]              m_addr,
   output logic [31:0]              m_wdata,
   input  logic [31:0]              m_rdata,
   input  logic                     m_rdy,
   output logic [$clog2(DEPTH):0]   wb_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL = LW'(DEPTH);

   typedef enum logic [1:0] {M_IDLE, M_ISSUE, M_WAIT} m_state_t;

   m_state_t      state_q, state_d;
   logic [31:0]   mem_addr [DEPTH];
   logic [31:0]   mem_data [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0] count;
   logic          rd_pend, fwd_hold;
   logic [31:0]   rd_addr;
   logic          accept, push, rd_acc;
   logic          pop, issue_rd, rd_done;
   logic          fwd_hit;
   logic [31:0]   fwd_data;

   assign s_rdy    = !rd_pend && !fwd_hold && (count != FULL);
   assign accept   = s_req && s_rdy;
   assign push     = accept && s_wr;
   assign rd_acc   = accept && !s_wr;
   assign wb_level = count;

`ifdef TXN_WR_BUFFER_FWD_EN
   // Scan valid entries oldest to youngest so the youngest match wins.
   always_comb begin
      logic [AW-1:0] idx;
      fwd_hit  = 1'b0;
      fwd_data = '0;
      idx      = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = rd_ptr + AW'(k);
         if ((LW'(k) < count) && (mem_addr[idx] == s_addr)) begin
            fwd_hit  = rd_acc;
            fwd_data = mem_data[idx];
         end
      end
   end
`else
   assign fwd_hit  = 1'b0;
   assign fwd_data = '0;
`endif

   // Downstream FSM next-state: buffered writes take priority over the pending read.
   always_comb begin
      state_d  = state_q;
      pop      = 1'b0;
      issue_rd = 1'b0;
      rd_done  = 1'b0;
      case (state_q)
         M_IDLE: begin
            if (m_rdy) begin
               if (count != '0) begin
                  pop     = 1'b1;
                  state_d = M_ISSUE;
               end else if (rd_pend) begin
                  issue_rd = 1'b1;
                  state_d  = M_ISSUE;
               end
            end
         end
         M_ISSUE: state_d = M_WAIT;
         M_WAIT: begin
            if (m_rdy) begin
               state_d = M_IDLE;
               rd_done = !m_wr;
            end
         end
         default: state_d = M_IDLE;
      endcase
   end

   // FIFO storage; flushed logically through the pointers and count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_addr[wr_ptr] <= s_addr;
         mem_data[wr_ptr] <= s_wdata;
      end
   end

   // State, FIFO bookkeeping, registered downstream request and read return.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= M_IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         rd_pend  <= 1'b0;
         rd_addr  <= '0;
         fwd_hold <= 1'b0;
         m_req    <= 1'b0;
         m_wr     <= 1'b0;
         m_addr   <= '0;
         m_wdata  <= '0;
         s_rdata  <= '0;
      end else begin
         state_q <= state_d;
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + LW'(1);
            2'b01:   count <= count - LW'(1);
            default: count <= count;
         endcase
         m_req <= pop || issue_rd;
         if (pop) begin
            m_wr    <= 1'b1;
            m_addr  <= mem_addr[rd_ptr];
            m_wdata <= mem_data[rd_ptr];
         end else if (issue_rd) begin
            m_wr    <= 1'b0;
            m_addr  <= rd_addr;
            m_wdata <= '0;
         end
         if (rd_acc) rd_addr <= s_addr;
         if (rd_done)
            rd_pend <= 1'b0;
         else if (rd_acc && !fwd_hit)
            rd_pend <= 1'b1;
         fwd_hold <= fwd_hit;
         if (rd_done)
            s_rdata <= m_rdata;
         else if (fwd_hit)
            s_rdata <= fwd_data;
      end
   end

endmodule

// File: tb/tb_txn_wr_buffer.sv
// Directed bench for txn_wr_buffer (DEPTH=4).
module tb_txn_wr_buffer;

   logic        clk, rst;
   logic        s_req, s_wr;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic        s_rdy;
   logic        m_req, m_wr;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic        m_rdy;
   logic [2:0]  wb_level;

   int n_chk  = 0;
   int n_fail = 0;

   bit          log_wr   [$];
   logic [31:0] log_addr [$];
   logic [31:0] log_data [$];

   txn_wr_buffer #(.DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .s_req(s_req), .s_wr(s_wr), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_rdata(s_rdata), .s_rdy(s_rdy),
      .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .m_rdy(m_rdy), .wb_level(wb_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Capture every cycle m_req is high.
   always @(negedge clk) begin
      if (m_req === 1'b1) begin
         log_wr.push_back(m_wr);
         log_addr.push_back(m_addr);
         log_data.push_back(m_wdata);
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d);
      s_req = 1'b1; s_wr = 1'b1; s_addr = a; s_wdata = d;
      cyc();
      s_req = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] a);
      s_req = 1'b1; s_wr = 1'b0; s_addr = a; s_wdata = '0;
      cyc();
      s_req = 1'b0;
   endtask

   initial begin
      int base, lat, sent;
      bit acc, done;
      rst = 1'b1; s_req = 0; s_wr = 0; s_addr = 0; s_wdata = 0;
      m_rdy = 0; m_rdata = 0;
      cyc(2);
      rst = 1'b0;

      // Reset values
      check_val("rst_s_rdy", 32'(s_rdy), 32'd1);
      check_val("rst_level", 32'(wb_level), 32'd0);
      check_val("rst_m_req", 32'(m_req), 32'd0);
      check_val("rst_m_wr", 32'(m_wr), 32'd0);
      check_val("rst_m_addr", m_addr, 32'h0);
      check_val("rst_m_wdata", m_wdata, 32'h0);
      check_val("rst_s_rdata", s_rdata, 32'h0);

      // Single write with m_rdy=1
      m_rdy = 1'b1;
      base = log_addr.size();
      do_write(32'h4000_1000, 32'hA5A5_A5A5);
      check_val("w1_s_rdy", 32'(s_rdy), 32'd1);
      check_val("w1_level", 32'(wb_level), 32'd1);
      check_val("w1_no_req_yet", 32'(m_req), 32'd0);
      cyc();
      check_val("w1_m_req", 32'(m_req), 32'd1);
      check_val("w1_m_wr", 32'(m_wr), 32'd1);
      check_val("w1_m_addr", m_addr, 32'h4000_1000);
      check_val("w1_m_wdata", m_wdata, 32'hA5A5_A5A5);
      cyc();
      check_val("w1_req_drop", 32'(m_req), 32'd0);
      check_val("w1_addr_hold", m_addr, 32'h4000_1000);
      cyc(4);
      check_val("w1_req_count", 32'(log_addr.size() - base), 32'd1);

      // Fill to DEPTH with m_rdy held low; fifth write ignored
      m_rdy = 1'b0;
      base = log_addr.size();
      for (int i = 0; i < 5; i++) do_write(32'h100 + 32'(4 * i), 32'hD0 + 32'(i));
      check_val("full_level", 32'(wb_level), 32'd4);
      check_val("full_s_rdy", 32'(s_rdy), 32'd0);
      check_val("full_no_req", 32'(log_addr.size() - base), 32'd0);
      m_rdy = 1'b1;
      cyc(20);
      check_val("full_drain_n", 32'(log_addr.size() - base), 32'd4);
      if (log_addr.size() - base >= 4)
         for (int i = 0; i < 4; i++) begin
            check_val($sformatf("full_addr%0d", i), log_addr[base + i], 32'h100 + 32'(4 * i));
            check_val($sformatf("full_data%0d", i), log_data[base + i], 32'hD0 + 32'(i));
         end
      check_val("full_empty", 32'(wb_level), 32'd0);

      // Three writes then a read: read goes out only after the writes
      m_rdy = 1'b0;
      m_rdata = 32'h1234_5678;
      base = log_addr.size();
      for (int i = 0; i < 3; i++) do_write(32'h200 + 32'(4 * i), 32'hE0 + 32'(i));
      do_read(32'h4000_0000);
      check_val("rd_s_rdy_low", 32'(s_rdy), 32'd0);
      m_rdy = 1'b1;
      done = 0;
      for (int t = 0; t < 60 && !done; t++) begin
         cyc();
         if (s_rdy) done = 1;
      end
      check_val("rd_timeout", 32'(done), 32'd1);
      check_val("rd_s_rdata", s_rdata, 32'h1234_5678);
      check_val("rd_req_n", 32'(log_addr.size() - base), 32'd4);
      if (log_addr.size() - base >= 4) begin
         for (int i = 0; i < 3; i++)
            check_val($sformatf("rd_prior_w%0d", i), log_addr[base + i], 32'h200 + 32'(4 * i));
         check_val("rd_last_is_rd", 32'(log_wr[base + 3]), 32'd0);
         check_val("rd_last_addr", log_addr[base + 3], 32'h4000_0000);
         check_val("rd_last_wdata", log_data[base + 3], 32'h0);
      end

      // Read latency with empty FIFO and one-cycle downstream latency
      m_rdata = 32'hCAFE_F00D;
      do_read(32'h300);
      lat = 1;
      done = 0;
      for (int t = 0; t < 20 && !done; t++) begin
         cyc();
         lat++;
         if (s_rdy) done = 1;
      end
      check_val("lat_cycles", 32'(lat), 32'd4);
      check_val("lat_s_rdata", s_rdata, 32'hCAFE_F00D);

      // Reset while in M_WAIT with two writes still buffered
      m_rdy = 1'b0;
      for (int i = 0; i < 3; i++) do_write(32'h500 + 32'(4 * i), 32'hF0 + 32'(i));
      base = log_addr.size();
      m_rdy = 1'b1;
      cyc();
      m_rdy = 1'b0;
      cyc();
      check_val("rstw_level_pre", 32'(wb_level), 32'd2);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check_val("rstw_level", 32'(wb_level), 32'd0);
      check_val("rstw_m_req", 32'(m_req), 32'd0);
      check_val("rstw_s_rdy", 32'(s_rdy), 32'd1);
      check_val("rstw_m_addr", m_addr, 32'h0);
      m_rdy = 1'b1;
      cyc(10);
      check_val("rstw_no_req", 32'(log_addr.size() - base), 32'd1);

      // Simultaneous push/pop at level 2, then a 20-entry stream across wrap
      m_rdy = 1'b0;
      base = log_addr.size();
      do_write(32'h600, 32'h1000);
      do_write(32'h604, 32'h1001);
      check_val("se_level_pre", 32'(wb_level), 32'd2);
      s_req = 1'b1; s_wr = 1'b1; s_addr = 32'h608; s_wdata = 32'h1002;
      m_rdy = 1'b1;
      cyc();
      s_req = 1'b0;
      check_val("se_level", 32'(wb_level), 32'd2);
      sent = 3;
      for (int t = 0; t < 400 && sent < 20; t++) begin
         acc = s_rdy;
         s_req = acc; s_wr = 1'b1;
         s_addr = 32'h600 + 32'(4 * sent); s_wdata = 32'h1000 + 32'(sent);
         cyc();
         if (acc) sent++;
      end
      s_req = 1'b0;
      check_val("stream_sent", 32'(sent), 32'd20);
      cyc(30);
      check_val("stream_n", 32'(log_addr.size() - base), 32'd20);
      if (log_addr.size() - base >= 20)
         for (int i = 0; i < 20; i++) begin
            check_val($sformatf("stream_addr%0d", i), log_addr[base + i], 32'h600 + 32'(4 * i));
            check_val($sformatf("stream_data%0d", i), log_data[base + i], 32'h1000 + 32'(i));
         end

`ifdef TXN_WR_BUFFER_FWD_EN
      // Forwarding from the youngest matching buffered write
      m_rdy = 1'b0;
      base = log_addr.size();
      do_write(32'h4000_1004, 32'h11);
      do_write(32'h4000_1004, 32'h22);
      do_read(32'h4000_1004);
      check_val("fwd_s_rdy_low", 32'(s_rdy), 32'd0);
      cyc();
      check_val("fwd_s_rdy", 32'(s_rdy), 32'd1);
      check_val("fwd_s_rdata", s_rdata, 32'h22);
      check_val("fwd_level", 32'(wb_level), 32'd2);
      check_val("fwd_no_req", 32'(log_addr.size() - base), 32'd0);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
